// File: rtl/rv32i_encode.sv
// rv32i_encode: packs an RV32I format class plus fields into a 32-bit instruction word.
// Latency: 2 stages (S1 raw fields, S2 encoded word); a word accepted at edge N is valid after edge N+1.
// Backpressure: valid/ready on both sides; S1+S2 buffer two words; in_ready = ~s1_valid | ~out_valid | out_ready.
// Optional RV32I_ENC_RANGE_CHECK_EN: also flag immediates that do not fit their format's field.
module rv32i_encode #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RST_INSTR = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_fmt,
    input  logic [4:0]      in_rd,
    input  logic [4:0]      in_rs1,
    input  logic [4:0]      in_rs2,
    input  logic [2:0]      in_funct3,
    input  logic [6:0]      in_funct7,
    input  logic [XLEN-1:0] in_imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic            out_err
);

    // Format classes as presented on in_fmt
    localparam logic [3:0] FMT_BRANCH = 4'd0;
    localparam logic [3:0] FMT_JALR   = 4'd1;
    localparam logic [3:0] FMT_JAL    = 4'd2;
    localparam logic [3:0] FMT_LUI    = 4'd3;
    localparam logic [3:0] FMT_AUIPC  = 4'd4;
    localparam logic [3:0] FMT_OP_IMM = 4'd5;
    localparam logic [3:0] FMT_OP     = 4'd6;
    localparam logic [3:0] FMT_LOAD   = 4'd7;
    localparam logic [3:0] FMT_STORE  = 4'd8;
    localparam logic [3:0] FMT_FENCE  = 4'd9;

    // Major opcodes
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_FENCE  = 7'h0F;

    // Stage 1: raw fields
    logic            s1_valid_q, s1_valid_d;
    logic [3:0]      s1_fmt_q;
    logic [4:0]      s1_rd_q;
    logic [4:0]      s1_rs1_q;
    logic [4:0]      s1_rs2_q;
    logic [2:0]      s1_funct3_q;
    logic [6:0]      s1_funct7_q;
    logic [XLEN-1:0] s1_imm_q;

    // Stage 2: encoded word
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_instr_q;
    logic            out_err_q;

    // Encoder result for the word sitting in S1
    logic [31:0]     enc_word;
    logic            enc_err;

    logic            accept;
    logic            s1_move;

`ifdef RV32I_ENC_RANGE_CHECK_EN
    // True when v equals the sign extension of its low 'bits' bits
    function automatic logic fits_signed(input logic [31:0] v, input int bits);
        logic [31:0] hi;
        hi = $unsigned($signed(v) >>> (bits - 1));
        return (hi == 32'h0) || (hi == 32'hFFFF_FFFF);
    endfunction
`endif

    // Handshake: S1 may advance whenever S2 is empty or being drained
    always_comb begin
        s1_move     = s1_valid_q & (~out_valid_q | out_ready);
        in_ready    = ~s1_valid_q | ~out_valid_q | out_ready;
        accept      = in_valid & in_ready;
        s1_valid_d  = accept | (s1_valid_q & ~s1_move);
        out_valid_d = out_valid_q;
        if (s1_move) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // S1 capture of raw fields on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_fmt_q    <= '0;
            s1_rd_q     <= '0;
            s1_rs1_q    <= '0;
            s1_rs2_q    <= '0;
            s1_funct3_q <= '0;
            s1_funct7_q <= '0;
            s1_imm_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (accept) begin
                s1_fmt_q    <= in_fmt;
                s1_rd_q     <= in_rd;
                s1_rs1_q    <= in_rs1;
                s1_rs2_q    <= in_rs2;
                s1_funct3_q <= in_funct3;
                s1_funct7_q <= in_funct7;
                s1_imm_q    <= in_imm;
            end
        end
    end

    // Field packing per format; fields a format does not use are never referenced
    always_comb begin
        enc_word = 32'h0;
        enc_err  = 1'b0;
        case (s1_fmt_q)
            FMT_BRANCH: begin
                enc_word = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                            s1_imm_q[4:1], s1_imm_q[11], OPC_BRANCH};
                enc_err  = s1_imm_q[0];
`ifdef RV32I_ENC_RANGE_CHECK_EN
                enc_err  = enc_err | ~fits_signed(s1_imm_q, 13);
`endif
            end
            FMT_JALR: begin
                // JALR only defines funct3 = 000
                enc_word = {s1_imm_q[11:0], s1_rs1_q, 3'b000, s1_rd_q, OPC_JALR};
`ifdef RV32I_ENC_RANGE_CHECK_EN
                enc_err  = ~fits_signed(s1_imm_q, 12);
`endif
            end
            FMT_JAL: begin
                enc_word = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                            s1_rd_q, OPC_JAL};
                enc_err  = s1_imm_q[0];
`ifdef RV32I_ENC_RANGE_CHECK_EN
                enc_err  = enc_err | ~fits_signed(s1_imm_q, 21);
`endif
            end
            FMT_LUI, FMT_AUIPC: begin
                enc_word = {s1_imm_q[31:12], s1_rd_q,
                            (s1_fmt_q == FMT_LUI) ? OPC_LUI : OPC_AUIPC};
`ifdef RV32I_ENC_RANGE_CHECK_EN
                enc_err  = (s1_imm_q[11:0] != 12'h0);
`endif
            end
            FMT_OP_IMM: begin
                if (s1_funct3_q == 3'b001 || s1_funct3_q == 3'b101) begin
                    // Shifts: funct7 selects logical/arithmetic, shamt from imm[4:0]
                    enc_word = {s1_funct7_q, s1_imm_q[4:0], s1_rs1_q, s1_funct3_q, s1_rd_q,
                                OPC_OP_IMM};
`ifdef RV32I_ENC_RANGE_CHECK_EN
                    enc_err  = (s1_imm_q[31:5] != 27'h0);
`endif
                end else begin
                    enc_word = {s1_imm_q[11:0], s1_rs1_q, s1_funct3_q, s1_rd_q, OPC_OP_IMM};
`ifdef RV32I_ENC_RANGE_CHECK_EN
                    enc_err  = ~fits_signed(s1_imm_q, 12);
`endif
                end
            end
            FMT_OP: begin
                enc_word = {s1_funct7_q, s1_rs2_q, s1_rs1_q, s1_funct3_q, s1_rd_q, OPC_OP};
            end
            FMT_LOAD, FMT_FENCE: begin
                enc_word = {s1_imm_q[11:0], s1_rs1_q, s1_funct3_q, s1_rd_q,
                            (s1_fmt_q == FMT_LOAD) ? OPC_LOAD : OPC_FENCE};
`ifdef RV32I_ENC_RANGE_CHECK_EN
                enc_err  = ~fits_signed(s1_imm_q, 12);
`endif
            end
            FMT_STORE: begin
                enc_word = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_funct3_q, s1_imm_q[4:0],
                            OPC_STORE};
`ifdef RV32I_ENC_RANGE_CHECK_EN
                enc_err  = ~fits_signed(s1_imm_q, 12);
`endif
            end
            default: begin
                // Unknown format: emit an all-zero word flagged as an error
                enc_word = 32'h0;
                enc_err  = 1'b1;
            end
        endcase
    end

    // S2: load encoded word when S1 advances, otherwise hold for the consumer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_instr_q <= RST_INSTR;
            out_err_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            if (s1_move) begin
                out_instr_q <= enc_word;
                out_err_q   <= enc_err;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_rv32i_encode.sv
// tb_rv32i_encode: directed vectors plus randomized traffic against a field-arithmetic reference model.
// Inputs change 1 time unit after posedge; handshakes and outputs are observed on the falling edge.
// Scoreboard queue holds expected {err, word} in accept order; every drained word is popped and compared.
module tb_rv32i_encode;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_fmt = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic        out_err;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_out    = 0;
    bit          acc;
    logic [32:0] exp_q[$];

    rv32i_encode #(.XLEN(32), .RST_INSTR(32'h0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Bits hi..lo of v as a plain number
    function automatic int unsigned fld(input int unsigned v, input int hi, input int lo);
        return (v >> lo) % (32'd1 << (hi - lo + 1));
    endfunction

    // Reference encoder: returns {err, word}
    function automatic logic [32:0] model(input int unsigned fmt, input int unsigned rd,
                                          input int unsigned rs1, input int unsigned rs2,
                                          input int unsigned f3, input int unsigned f7,
                                          input int unsigned imm);
        int unsigned w;
        int signed   si;
        bit          err, rng;
        si  = imm;
        err = 0;
        rng = 0;
        case (fmt)
            0: begin
                w   = (fld(imm,12,12) << 31) + (fld(imm,10,5) << 25) + (rs2 << 20) + (rs1 << 15)
                    + (f3 << 12) + (fld(imm,4,1) << 8) + (fld(imm,11,11) << 7) + 'h63;
                err = (imm % 2) != 0;
                rng = si < -4096 || si > 4095;
            end
            1: begin
                w   = (fld(imm,11,0) << 20) + (rs1 << 15) + (rd << 7) + 'h67;
                rng = si < -2048 || si > 2047;
            end
            2: begin
                w   = (fld(imm,20,20) << 31) + (fld(imm,10,1) << 21) + (fld(imm,11,11) << 20)
                    + (fld(imm,19,12) << 12) + (rd << 7) + 'h6F;
                err = (imm % 2) != 0;
                rng = si < -(1 << 20) || si > (1 << 20) - 1;
            end
            3, 4: begin
                w   = (imm - (imm % 4096)) + (rd << 7) + ((fmt == 3) ? 'h37 : 'h17);
                rng = (imm % 4096) != 0;
            end
            5: begin
                if (f3 == 1 || f3 == 5) begin
                    w   = (f7 << 25) + ((imm % 32) << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 'h13;
                    rng = imm > 31;
                end else begin
                    w   = (fld(imm,11,0) << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 'h13;
                    rng = si < -2048 || si > 2047;
                end
            end
            6: w = (f7 << 25) + (rs2 << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 'h33;
            7, 9: begin
                w   = (fld(imm,11,0) << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7)
                    + ((fmt == 7) ? 'h03 : 'h0F);
                rng = si < -2048 || si > 2047;
            end
            8: begin
                w   = (fld(imm,11,5) << 25) + (rs2 << 20) + (rs1 << 15) + (f3 << 12)
                    + (fld(imm,4,0) << 7) + 'h23;
                rng = si < -2048 || si > 2047;
            end
            default: begin
                w   = 0;
                err = 1;
            end
        endcase
`ifdef RV32I_ENC_RANGE_CHECK_EN
        err = err | rng;
`else
        rng = 0;
`endif
        return {err, w};
    endfunction

    // One cycle: observe the handshakes due at the next posedge, then advance past it
    task automatic step();
        logic [32:0] e;
        @(negedge clk);
        acc = 0;
        if (out_valid && out_ready) begin
            chk("sb_has_exp", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_instr", out_instr, e[31:0]);
                chk("sb_err", out_err, e[32]);
                n_out++;
            end
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(model(in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm));
            acc = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int unsigned fmt, input int unsigned rd, input int unsigned rs1,
                          input int unsigned rs2, input int unsigned f3, input int unsigned f7,
                          input logic [31:0] imm);
        in_fmt    = fmt[3:0];
        in_rd     = rd[4:0];
        in_rs1    = rs1[4:0];
        in_rs2    = rs2[4:0];
        in_funct3 = f3[2:0];
        in_funct7 = f7[6:0];
        in_imm    = imm;
    endtask

    // Single word through an empty pipe; checks against a constant and the one-edge latency
    task automatic directed(input string tag, input logic [31:0] exp_w, input logic exp_e,
                            input bit chk_lat);
        int lat;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        step();
        chk({tag, "_acc"}, acc, 1);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (chk_lat) chk({tag, "_lat"}, lat, 1);
        chk({tag, "_instr"}, out_instr, exp_w);
        chk({tag, "_err"}, out_err, exp_e);
        step();
    endtask

    task automatic load_stall(input int k);
        set_in(6, k + 1, k + 4, k + 9, k, 7'h20 * (k % 2), 0);
    endtask

    initial begin
        int k, guard, base;
        int unsigned mode, r;

        // Reset state
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_out_err", out_err, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);

        // Directed encodings
        set_in(5, 1, 0, 0, 0, 0, 5);               directed("opimm", 32'h00500093, 0, 1);
        set_in(6, 3, 1, 2, 0, 0, 0);               directed("op", 32'h002081B3, 0, 0);
        set_in(0, 0, 1, 2, 0, 0, 8);               directed("branch", 32'h00208463, 0, 0);
        set_in(2, 1, 0, 0, 0, 0, 2048);            directed("jal", 32'h001000EF, 0, 0);
        set_in(3, 5, 0, 0, 0, 0, 32'h12345000);    directed("lui", 32'h123452B7, 0, 0);
        set_in(8, 0, 1, 2, 2, 0, 12);              directed("store", 32'h0020A623, 0, 0);
        set_in(12, 7, 3, 4, 5, 6, 32'hFFFF_FFFF);  directed("badfmt", 32'h0, 1, 0);
        set_in(0, 0, 0, 0, 0, 0, 7);               directed("br_misalign", 32'h00000363, 1, 0);
        set_in(1, 1, 2, 0, 3'b111, 0, 4);          directed("jalr_f3", 32'h004100E7, 0, 0);
`ifdef RV32I_ENC_RANGE_CHECK_EN
        set_in(5, 0, 0, 0, 0, 0, 4096);            directed("opimm_range", 32'h00000013, 1, 0);
`else
        set_in(5, 0, 0, 0, 0, 0, 4096);            directed("opimm_range", 32'h00000013, 0, 0);
`endif

        // Stall: three back-to-back words with the consumer blocked
        base = n_out;
        out_ready = 1'b0;
        k = 0;
        load_stall(k);
        in_valid = 1'b1;
        repeat (4) begin
            step();
            if (acc) begin
                k++;
                if (k < 3) load_stall(k);
            end
        end
        chk("stall_accepted", k, 2);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_out_valid", out_valid, 1);
        out_ready = 1'b1;
        guard = 0;
        while ((k < 3 || exp_q.size() > 0) && guard < 20) begin
            step();
            if (acc) begin
                k++;
                if (k >= 3) in_valid = 1'b0;
                else load_stall(k);
            end
            guard++;
        end
        in_valid = 1'b0;
        chk("stall_all_acc", k, 3);
        chk("stall_drained", exp_q.size(), 0);
        chk("stall_out_count", n_out - base, 3);

        // Asynchronous reset with both stages full
        out_ready = 1'b0;
        k = 0;
        load_stall(k);
        in_valid = 1'b1;
        repeat (4) begin
            step();
            if (acc) begin
                k++;
                load_stall(k);
            end
        end
        in_valid = 1'b0;
        chk("arst_full", in_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_instr", out_instr, 32'h0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        chk("arst_in_ready", in_ready, 1);
        repeat (3) step();
        chk("arst_no_stale", out_valid, 0);

        // Randomized traffic
        base = n_out;
        repeat (600) begin
            mode = $urandom_range(0, 3);
            case (mode)
                0: r = $urandom_range(0, 4095) - 2048;
                1: r = $urandom;
                2: r = $urandom & 32'hFFFF_F000;
                default: r = $urandom_range(0, 40);
            endcase
            set_in(($urandom_range(0, 15) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9),
                   $urandom, $urandom, $urandom, $urandom, $urandom, r);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            step();
            guard++;
        end
        chk("rand_drained", exp_q.size(), 0);
        chk("rand_out_seen", (n_out - base > 100), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
